// File: rtl/srcmp_pkg.sv
// Shared definitions for the multi-channel set/reset comparator.
//   ch_width      : width of a channel index for a given channel count.
//   threshold_hit : threshold match test on zero-extended operands.
// Optional feature macro: SRCMP_CROSSING_DETECT_EN (step-tolerant crossing
// detection; without it a match is plain equality).
package srcmp_pkg;

    // Operands are zero-extended to this width before comparison, so WIDTH
    // of the comparator must not exceed it.
    localparam int unsigned CMP_MAX_W = 64;

    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? 32'($clog2(n)) : 32'd1;
    endfunction

    function automatic logic threshold_hit(
        input logic [CMP_MAX_W-1:0] curr,
        input logic [CMP_MAX_W-1:0] prev,
        input logic                 prev_valid,
        input logic [CMP_MAX_W-1:0] th
    );
`ifdef SRCMP_CROSSING_DETECT_EN
        logic hit;
        if (!prev_valid || (curr == prev)) begin
            hit = (curr == th);
        end else if (curr > prev) begin
            // Forward step: threshold lies in (prev, curr].
            hit = (th > prev) && (th <= curr);
        end else begin
            // Step across the wrap point: (prev, max] or [0, curr].
            hit = (th > prev) || (th <= curr);
        end
        return hit;
`else
        logic unused_crossing;
        unused_crossing = prev_valid ^ (^prev);
        return (curr == th);
`endif
    endfunction

endpackage

// File: rtl/set_reset_channel.sv
// One comparator channel: double-buffered set/reset thresholds, pending
// flag, priority next-state logic, registered output and edge events.
// Ports:
//   clk, arst_n             clock, async active-low reset
//   data_compare, data_valid current counter sample and its qualifier
//   prev_data, prev_valid   last valid sample (crossing detection)
//   wr_en, wr_set, wr_reset decoded shadow write for this channel
//   update                  commit strobe
//   ch_en, out_clr          channel enable, synchronous output clear
//   out, set_evt, reset_evt registered output and one-cycle events
//   pending                 shadow written but not yet committed
module set_reset_channel
    import srcmp_pkg::*;
#(
    parameter int unsigned WIDTH = 24
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [WIDTH-1:0] data_compare,
    input  logic             data_valid,
    input  logic [WIDTH-1:0] prev_data,
    input  logic             prev_valid,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_set,
    input  logic [WIDTH-1:0] wr_reset,
    input  logic             update,
    input  logic             ch_en,
    input  logic             out_clr,
    output logic             out,
    output logic             set_evt,
    output logic             reset_evt,
    output logic             pending
);

    logic [WIDTH-1:0] shadow_set;
    logic [WIDTH-1:0] shadow_reset;
    logic [WIDTH-1:0] active_set;
    logic [WIDTH-1:0] active_reset;

    logic set_hit_c;
    logic reset_hit_c;
    logic out_nxt;
    logic set_evt_nxt;
    logic reset_evt_nxt;

    // Threshold matches against the active pair as it stands this cycle.
    assign set_hit_c   = data_valid && threshold_hit(CMP_MAX_W'(data_compare), CMP_MAX_W'(prev_data),
                                                     prev_valid, CMP_MAX_W'(active_set));
    assign reset_hit_c = data_valid && threshold_hit(CMP_MAX_W'(data_compare), CMP_MAX_W'(prev_data),
                                                     prev_valid, CMP_MAX_W'(active_reset));

    // Shadow/active double buffer; a same-cycle write leaves the new pair pending.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            shadow_set   <= '0;
            shadow_reset <= '0;
            active_set   <= '0;
            active_reset <= '0;
            pending      <= 1'b0;
        end else begin
            if (update && pending) begin
                active_set   <= shadow_set;
                active_reset <= shadow_reset;
            end
            if (wr_en) begin
                shadow_set   <= wr_set;
                shadow_reset <= wr_reset;
                pending      <= 1'b1;
            end else if (update) begin
                pending      <= 1'b0;
            end
        end
    end

    // Output priority: disable/clear, then reset match, then set match.
    always_comb begin
        out_nxt       = out;
        set_evt_nxt   = 1'b0;
        reset_evt_nxt = 1'b0;
        if (!ch_en || out_clr) begin
            out_nxt = 1'b0;
        end else if (reset_hit_c) begin
            out_nxt       = 1'b0;
            reset_evt_nxt = out;
        end else if (set_hit_c) begin
            out_nxt     = 1'b1;
            set_evt_nxt = !out;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            out       <= 1'b0;
            set_evt   <= 1'b0;
            reset_evt <= 1'b0;
        end else begin
            out       <= out_nxt;
            set_evt   <= set_evt_nxt;
            reset_evt <= reset_evt_nxt;
        end
    end

endmodule

// File: rtl/multi_set_reset_comparator.sv
// Multi-channel set/reset comparator for the angle path. Each channel's
// output turns on at its set threshold and off at its reset threshold;
// thresholds are written to shadows and committed atomically by update.
// Ports:
//   clk, arst_n               clock, async active-low reset
//   data_compare, data_valid  angle counter sample and qualifier
//   wr_en, wr_ch, wr_set, wr_reset  shadow write (out-of-range wr_ch ignored)
//   update                    commit all pending shadows
//   ch_en, out_clr            per-channel enable and synchronous clear
//   out, set_evt, reset_evt   registered outputs and one-cycle events
//   pending                   per-channel uncommitted shadow flag
// Optional feature macro: SRCMP_CROSSING_DETECT_EN (keeps the last valid
// sample so thresholds skipped by a multi-count step still match).
module multi_set_reset_comparator
    import srcmp_pkg::*;
#(
    parameter  int unsigned WIDTH    = 24,
    parameter  int unsigned CHANNELS = 4,
    localparam int unsigned CH_W     = ch_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic [WIDTH-1:0]    data_compare,
    input  logic                data_valid,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [WIDTH-1:0]    wr_set,
    input  logic [WIDTH-1:0]    wr_reset,
    input  logic                update,
    input  logic [CHANNELS-1:0] ch_en,
    input  logic [CHANNELS-1:0] out_clr,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] set_evt,
    output logic [CHANNELS-1:0] reset_evt,
    output logic [CHANNELS-1:0] pending
);

    logic             wr_ok_c;
    logic [WIDTH-1:0] prev_data;
    logic             prev_valid;

    // Writes to a channel index beyond CHANNELS are dropped.
    assign wr_ok_c = wr_en && (32'(wr_ch) < CHANNELS);

`ifdef SRCMP_CROSSING_DETECT_EN
    // Last valid counter sample, shared by all channels.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            prev_data  <= '0;
            prev_valid <= 1'b0;
        end else if (data_valid) begin
            prev_data  <= data_compare;
            prev_valid <= 1'b1;
        end
    end
`else
    assign prev_data  = '0;
    assign prev_valid = 1'b0;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        set_reset_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk          (clk),
            .arst_n       (arst_n),
            .data_compare (data_compare),
            .data_valid   (data_valid),
            .prev_data    (prev_data),
            .prev_valid   (prev_valid),
            .wr_en        (wr_ok_c && (wr_ch == CH_W'(i))),
            .wr_set       (wr_set),
            .wr_reset     (wr_reset),
            .update       (update),
            .ch_en        (ch_en[i]),
            .out_clr      (out_clr[i]),
            .out          (out[i]),
            .set_evt      (set_evt[i]),
            .reset_evt    (reset_evt[i]),
            .pending      (pending[i])
        );
    end

endmodule

// File: tb/tb_multi_set_reset_comparator.sv
// Directed bench for multi_set_reset_comparator (WIDTH=24, CHANNELS=4, plus
// a CHANNELS=3 instance for out-of-range channel writes).
module tb_multi_set_reset_comparator;

`ifdef SRCMP_CROSSING_DETECT_EN
    localparam logic XD = 1'b1;
`else
    localparam logic XD = 1'b0;
`endif

    logic        clk;
    logic        arst_n;
    logic [23:0] data_compare;
    logic        data_valid;
    logic        wr_en;
    logic [1:0]  wr_ch;
    logic [23:0] wr_set;
    logic [23:0] wr_reset;
    logic        update;
    logic [3:0]  ch_en;
    logic [3:0]  out_clr;
    logic [3:0]  out;
    logic [3:0]  set_evt;
    logic [3:0]  reset_evt;
    logic [3:0]  pending;

    logic        wr_en3;
    logic [1:0]  wr_ch3;
    logic [2:0]  ch_en3;
    logic [2:0]  out_clr3;
    logic [2:0]  out3;
    logic [2:0]  set_evt3;
    logic [2:0]  reset_evt3;
    logic [2:0]  pending3;

    int checks = 0;
    int errors = 0;

    multi_set_reset_comparator #(.WIDTH(24), .CHANNELS(4)) dut (
        .clk(clk), .arst_n(arst_n), .data_compare(data_compare), .data_valid(data_valid),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_set(wr_set), .wr_reset(wr_reset), .update(update),
        .ch_en(ch_en), .out_clr(out_clr), .out(out), .set_evt(set_evt),
        .reset_evt(reset_evt), .pending(pending)
    );

    multi_set_reset_comparator #(.WIDTH(24), .CHANNELS(3)) dut3 (
        .clk(clk), .arst_n(arst_n), .data_compare(data_compare), .data_valid(data_valid),
        .wr_en(wr_en3), .wr_ch(wr_ch3), .wr_set(wr_set), .wr_reset(wr_reset), .update(update),
        .ch_en(ch_en3), .out_clr(out_clr3), .out(out3), .set_evt(set_evt3),
        .reset_evt(reset_evt3), .pending(pending3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic write_sh(input logic [1:0] ch, input logic [23:0] s, input logic [23:0] r);
        wr_en = 1'b1; wr_ch = ch; wr_set = s; wr_reset = r;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic commit();
        update = 1'b1;
        tick();
        update = 1'b0;
    endtask

    task automatic sample(input logic [23:0] v);
        data_valid = 1'b1; data_compare = v;
        tick();
        data_valid = 1'b0;
    endtask

    initial begin
        arst_n = 1'b0; data_compare = '0; data_valid = 1'b0;
        wr_en = 1'b0; wr_ch = '0; wr_set = '0; wr_reset = '0; update = 1'b0;
        ch_en = 4'hF; out_clr = '0;
        wr_en3 = 1'b0; wr_ch3 = '0; ch_en3 = 3'b111; out_clr3 = '0;
        tick(); tick();
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_evt", 32'({set_evt, reset_evt}), 32'h0);
        arst_n = 1'b1;
        tick();

        // Reset and write: ch1 = 100/200
        write_sh(2'd1, 24'd100, 24'd200);
        chk("wr_pending", 32'(pending), 32'h2);
        commit();
        chk("commit_pending", 32'(pending), 32'h0);
        chk("commit_out", 32'(out), 32'h0);

        // Equality switching on ch1, counter 98..202
        for (int v = 98; v <= 202; v++) begin
            sample(24'(v));
            chk("eq_out1", 32'(out[1]), 32'((v >= 100) && (v < 200)));
            chk("eq_set_evt1", 32'(set_evt[1]), 32'(v == 100));
            chk("eq_reset_evt1", 32'(reset_evt[1]), 32'(v == 200));
        end

        // Same-cycle write and commit on ch0
        write_sh(2'd0, 24'd10, 24'd20);
        wr_en = 1'b1; wr_ch = 2'd0; wr_set = 24'd30; wr_reset = 24'd40;
        update = 1'b1; data_valid = 1'b1; data_compare = 24'd10;
        tick();
        wr_en = 1'b0; update = 1'b0; data_valid = 1'b0;
        chk("same_cyc_out", 32'(out), 32'h0);
        chk("same_cyc_pending", 32'(pending), 32'h1);
        sample(24'd10);
        chk("old_set_out", 32'(out), 32'h1);
        chk("old_set_evt", 32'(set_evt), 32'h1);
        sample(24'd20);
        chk("old_reset_out", 32'(out), 32'h0);
        chk("old_reset_evt", 32'(reset_evt), 32'h1);
        sample(24'd30);
        chk("not_yet_active", 32'(out), 32'h0);
        commit();
        chk("late_commit_pending", 32'(pending), 32'h0);
        sample(24'd30);
        chk("new_set_out", 32'(out), 32'h1);
        sample(24'd40);
        chk("new_reset_out", 32'(out), 32'h0);

        // Reset-wins conflicts on ch2
        write_sh(2'd2, 24'd50, 24'd50);
        commit();
        sample(24'd50);
        chk("eq_th_out", 32'(out), 32'h0);
        chk("eq_th_set_evt", 32'(set_evt), 32'h0);
        write_sh(2'd2, 24'd60, 24'd70);
        commit();
        sample(24'd60);
        chk("ch2_on", 32'(out), 32'h4);
        chk("ch2_set_evt", 32'(set_evt), 32'h4);
        sample(24'd60);
        chk("ch2_reset_again_out", 32'(out), 32'h4);
        chk("ch2_no_dup_evt", 32'(set_evt), 32'h0);
        out_clr = 4'h4;
        sample(24'd70);
        out_clr = 4'h0;
        chk("clr_out", 32'(out), 32'h0);
        chk("clr_no_reset_evt", 32'(reset_evt), 32'h0);

        // Step skip on ch3 (set=101, reset=5)
        write_sh(2'd3, 24'd101, 24'd5);
        commit();
        sample(24'd99);
        chk("skip_99", 32'(out[3]), 32'h0);
        sample(24'd103);
        chk("skip_103_out", 32'(out[3]), 32'(XD));
        chk("skip_103_evt", 32'(set_evt[3]), 32'(XD));
        sample(24'hFFFFFE);
        chk("skip_top_out", 32'(out[3]), 32'(XD));
        sample(24'h000006);
        chk("wrap_out", 32'(out[3]), 32'h0);
        chk("wrap_reset_evt", 32'(reset_evt[3]), 32'(XD));

        // All channels on, enable gating, out-of-range write, async reset
        for (int c = 0; c < 4; c++) write_sh(2'(c), 24'd500, 24'd900);
        chk("all_pending", 32'(pending), 32'hF);
        commit();
        sample(24'd500);
        chk("all_on", 32'(out), 32'hF);
        chk("all_set_evt", 32'(set_evt), 32'hF);
        ch_en = 4'hE;
        tick();
        chk("disable_out", 32'(out), 32'hE);
        chk("disable_no_evt", 32'(reset_evt), 32'h0);
        ch_en = 4'hF;
        sample(24'd500);
        chk("reenable_out", 32'(out), 32'hF);
        chk("reenable_evt", 32'(set_evt), 32'h1);
        wr_en3 = 1'b1; wr_ch3 = 2'd3;
        tick();
        chk("oob_write_ignored", 32'(pending3), 32'h0);
        wr_ch3 = 2'd2;
        tick();
        wr_en3 = 1'b0;
        chk("inrange_write", 32'(pending3), 32'h4);
        chk("pre_arst_out", 32'(out), 32'hF);

        #2 arst_n = 1'b0;
        #1;
        chk("arst_out", 32'(out), 32'h0);
        chk("arst_evt", 32'({set_evt, reset_evt}), 32'h0);
        chk("arst_pending", 32'({pending3, pending}), 32'h0);
        tick();
        chk("arst_hold_out", 32'(out), 32'h0);
        chk("arst_hold_evt", 32'({set_evt, reset_evt}), 32'h0);
        arst_n = 1'b1;
        tick();
        chk("post_arst_out", 32'(out), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
